sharpen_frame_ctrl: RTL

//  Frame sequencer for the 3x3 sharpening datapath. Accepts a raster pixel stream under valid/ready.

---
 rtl/sharpen_pkg.sv | 22 ++
 rtl/sharpen_raster_cnt.sv | 52 +++++
 rtl/sharpen_frame_ctrl.sv | 92 +++++++++
 3 files changed

// File: rtl/sharpen_pkg.sv
// Types and constants shared by the sharpening frame sequencer and its 3x3 datapath.
package sharpen_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int WIN_SIZE = 3;

  // Unsharp-mask kernel: centre weight and the weight shared by the 8 neighbours.
  localparam int KERNEL_CENTER   = 9;
  localparam int KERNEL_NEIGHBOR = -1;
  localparam int KERNEL_SHIFT    = 0;

  // Line-buffer row slot rotation 0 -> 1 -> 2 -> 0.
  function automatic logic [1:0] next_sel(input logic [1:0] sel);
    return (sel == 2'd2) ? 2'd0 : sel + 2'd1;
  endfunction

endpackage

// File: rtl/sharpen_raster_cnt.sv
// Raster column/row counter with line-buffer slot rotation; advances once per accepted pixel.
// Zero latency for last; counters hold whenever adv is low.
module sharpen_raster_cnt
  import sharpen_pkg::*;
#(
  parameter int WIDTH  = 768,
  parameter int HEIGHT = 512,
  parameter int CW     = 10,
  parameter int RW     = 10
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          clr,
  input  logic          adv,
  output logic [CW-1:0] col,
  output logic [RW-1:0] row,
  output logic [1:0]    sel,
  output logic          last
);

  localparam logic [CW-1:0] COL_LAST = CW'(WIDTH - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(HEIGHT - 1);

  assign last = (col == COL_LAST) && (row == ROW_LAST);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      col <= '0;
      row <= '0;
      sel <= 2'd0;
    end else if (clr) begin
      col <= '0;
      row <= '0;
      sel <= 2'd0;
    end else if (adv) begin
      if (col == COL_LAST) begin
        col <= '0;
        // Frame end restarts the slot rotation so every frame's row 0 lands in slot 0.
        if (row == ROW_LAST) begin
          row <= '0;
          sel <= 2'd0;
        end else begin
          row <= row + RW'(1);
          sel <= next_sel(sel);
        end
      end else begin
        col <= col + CW'(1);
      end
    end
  end

endmodule

// File: rtl/sharpen_frame_ctrl.sv
// Frame sequencer for the 3x3 sharpen datapath: raster tracking, line-buffer slot select, window flags.
// Accept is combinational (s_ready follows m_ready); win_valid/ctr_* lag the accept by one cycle.
module sharpen_frame_ctrl
  import sharpen_pkg::*;
#(
  parameter int WIDTH  = 768,
  parameter int HEIGHT = 512,
  parameter int CW     = 10,
  parameter int RW     = 10
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  input  logic          abort,
  input  logic          s_valid,
  output logic          s_ready,
  input  logic          m_ready,
  output logic          pix_en,
  output logic [CW-1:0] wr_col,
  output logic [1:0]    wr_sel,
  output logic          win_valid,
  output logic [CW-1:0] ctr_col,
  output logic [RW-1:0] ctr_row,
  output logic          busy,
  output logic          frame_done
);

  state_t        state, state_nxt;
  logic [RW-1:0] row;
  logic          last_pix;
  logic          win_hit;

  sharpen_raster_cnt #(
    .WIDTH (WIDTH),
    .HEIGHT(HEIGHT),
    .CW    (CW),
    .RW    (RW)
  ) u_cnt (
    .clk  (clk),
    .reset(reset),
    .clr  (abort),
    .adv  (pix_en),
    .col  (wr_col),
    .row  (row),
    .sel  (wr_sel),
    .last (last_pix)
  );

  assign s_ready    = (state == RUN) && m_ready && !abort;
  assign pix_en     = s_valid && s_ready;
  assign busy       = (state == RUN);
  assign frame_done = (state == DONE) && !abort;

  // A pixel at (col,row) closes the window whose centre is one step up and left.
  assign win_hit = pix_en && (row >= RW'(WIN_SIZE - 1)) && (wr_col >= CW'(WIN_SIZE - 1));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (start && !abort) state_nxt = RUN;
      RUN: begin
        if (abort) state_nxt = IDLE;
        else if (pix_en && last_pix) state_nxt = DONE;
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      win_valid <= 1'b0;
      ctr_col   <= '0;
      ctr_row   <= '0;
    end else begin
      win_valid <= win_hit;
      if (win_hit) begin
        ctr_col <= wr_col - CW'(1);
        ctr_row <= row - RW'(1);
      end
    end
  end

endmodule
